// File: rtl/vt_pkg.sv
// rtl/vt_pkg.sv - shared raster timing defaults and trim/polarity config type.
package vt_pkg;

    localparam int DEF_HTOTAL    = 383;
    localparam int DEF_VTOTAL    = 263;
    localparam int DEF_HBL_START = 256;
    localparam int DEF_HBL_END   = 0;
    localparam int DEF_VBL_START = 241;
    localparam int DEF_VBL_END   = 17;
    localparam int DEF_HS_START  = 297;
    localparam int DEF_HS_END    = 329;
    localparam int DEF_VS_START  = 257;
    localparam int DEF_VS_END    = 265;

    typedef struct packed {
        logic signed [3:0] hs_offset;
        logic signed [3:0] vs_offset;
        logic signed [3:0] hs_width;
        logic signed [3:0] vs_width;
        logic              hs_pol;
        logic              vs_pol;
    } vt_trim_t;

endpackage

// File: rtl/video_timing_gen_if.sv
// rtl/video_timing_gen_if.sv - timing config inputs and raster outputs of video_timing_gen.
interface video_timing_gen_if #(
    parameter int CW = 9
);
    logic [CW-1:0]     cfg_htotal, cfg_vtotal;
    logic [CW-1:0]     cfg_hbl_start, cfg_hbl_end, cfg_vbl_start, cfg_vbl_end;
    logic [CW-1:0]     cfg_hs_start, cfg_hs_end, cfg_vs_start, cfg_vs_end;
    logic signed [3:0] hs_offset, vs_offset, hs_width, vs_width;
    logic              cfg_hs_pol, cfg_vs_pol;
    logic [CW-1:0]     cfg_irq_line;
    logic [CW-1:0]     hc, vc;
    logic              hbl, vbl, hsync, vsync, de, field, irq;

    modport master (
        output cfg_htotal, cfg_vtotal, cfg_hbl_start, cfg_hbl_end, cfg_vbl_start, cfg_vbl_end,
        output cfg_hs_start, cfg_hs_end, cfg_vs_start, cfg_vs_end,
        output hs_offset, vs_offset, hs_width, vs_width, cfg_hs_pol, cfg_vs_pol, cfg_irq_line,
        input  hc, vc, hbl, vbl, hsync, vsync, de, field, irq
    );

    modport slave (
        input  cfg_htotal, cfg_vtotal, cfg_hbl_start, cfg_hbl_end, cfg_vbl_start, cfg_vbl_end,
        input  cfg_hs_start, cfg_hs_end, cfg_vs_start, cfg_vs_end,
        input  hs_offset, vs_offset, hs_width, vs_width, cfg_hs_pol, cfg_vs_pol, cfg_irq_line,
        output hc, vc, hbl, vbl, hsync, vsync, de, field, irq
    );
endinterface

// File: rtl/vt_axis.sv
// rtl/vt_axis.sv - one raster axis: counter, blank/sync set-clear flags, load-time sync fold.
module vt_axis #(
    parameter int CW = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce,
    input  logic              step,
    input  logic [CW-1:0]     raw_total,
    input  logic [CW-1:0]     raw_s_start,
    input  logic [CW-1:0]     raw_s_end,
    input  logic signed [3:0] offset,
    input  logic signed [3:0] width,
    output logic [CW-1:0]     adj_total,
    output logic [CW-1:0]     adj_s_start,
    output logic [CW-1:0]     adj_s_end,
    input  logic [CW-1:0]     total,
    input  logic [CW-1:0]     bl_start,
    input  logic [CW-1:0]     bl_end,
    input  logic [CW-1:0]     s_start,
    input  logic [CW-1:0]     s_end,
    output logic [CW-1:0]     cnt,
    output logic              last,
    output logic              bl,
    output logic              sy
);

    localparam int SW = CW + 2;

    logic signed [SW-1:0] period, s_raw, e_raw, off_x, wid_x;

    // Single correction is enough: trims are at most +-8 each, far below one period.
    function automatic logic [CW-1:0] fold(input logic signed [SW-1:0] x,
                                           input logic signed [SW-1:0] p);
        logic signed [SW-1:0] r;
        if (x < 0)       r = x + p;
        else if (x >= p) r = x - p;
        else             r = x;
        return r[CW-1:0];
    endfunction

    always_comb begin
        adj_total   = (raw_total == '0) ? CW'(1) : raw_total;
        period      = $signed({2'b00, adj_total}) + SW'(1);
        off_x       = {{(SW-4){offset[3]}}, offset};
        wid_x       = {{(SW-4){width[3]}}, width};
        s_raw       = $signed({2'b00, raw_s_start}) + off_x;
        e_raw       = $signed({2'b00, raw_s_end}) + off_x + wid_x;
        adj_s_start = fold(s_raw, period);
        adj_s_end   = fold(e_raw, period);
    end

    assign last = (cnt == total);

    always_ff @(posedge clk) begin
        if (reset)     cnt <= '0;
        else if (step) cnt <= last ? '0 : cnt + 1'b1;
    end

    // Set wins over clear when start and end coincide.
    always_ff @(posedge clk) begin
        if (reset) begin
            bl <= 1'b0;
            sy <= 1'b0;
        end else if (ce) begin
            if (cnt == bl_start)    bl <= 1'b1;
            else if (cnt == bl_end) bl <= 1'b0;
            if (cnt == s_start)     sy <= 1'b1;
            else if (cnt == s_end)  sy <= 1'b0;
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster timing generator with frame-boundary shadowed config.
module video_timing_gen
    import vt_pkg::*;
#(
    parameter int CW     = 9,
    parameter bit IRQ_EN = 1'b1
) (
    input logic               clk,
    input logic               reset,
    input logic               ce_pix,
    video_timing_gen_if.slave vif
);

    vt_trim_t      trim;
    logic          load, h_last, v_last, h_bl, v_bl, h_sy, v_sy, field_q;
    logic [CW-1:0] h_cnt, v_cnt;
    logic [CW-1:0] h_adj_total, h_adj_start, h_adj_end;
    logic [CW-1:0] v_adj_total, v_adj_start, v_adj_end;
    logic [CW-1:0] sh_htotal, sh_vtotal, sh_hbl_start, sh_hbl_end, sh_vbl_start, sh_vbl_end;
    logic [CW-1:0] sh_hs_start, sh_hs_end, sh_vs_start, sh_vs_end, sh_irq_line;
    logic          sh_hs_pol, sh_vs_pol;

    always_comb begin
        trim = '{hs_offset: vif.hs_offset, vs_offset: vif.vs_offset,
                 hs_width:  vif.hs_width,  vs_width:  vif.vs_width,
                 hs_pol:    vif.cfg_hs_pol, vs_pol:   vif.cfg_vs_pol};
    end

    // Reset loads the shadows too, so a frame after reset uses the live config.
    assign load = reset | (ce_pix & h_last & v_last);

    always_ff @(posedge clk) begin
        if (load) begin
            sh_htotal    <= h_adj_total;
            sh_vtotal    <= v_adj_total;
            sh_hbl_start <= vif.cfg_hbl_start;
            sh_hbl_end   <= vif.cfg_hbl_end;
            sh_vbl_start <= vif.cfg_vbl_start;
            sh_vbl_end   <= vif.cfg_vbl_end;
            sh_hs_start  <= h_adj_start;
            sh_hs_end    <= h_adj_end;
            sh_vs_start  <= v_adj_start;
            sh_vs_end    <= v_adj_end;
            sh_irq_line  <= vif.cfg_irq_line;
            sh_hs_pol    <= trim.hs_pol;
            sh_vs_pol    <= trim.vs_pol;
        end
    end

    vt_axis #(.CW(CW)) u_h (
        .clk(clk), .reset(reset), .ce(ce_pix), .step(ce_pix),
        .raw_total(vif.cfg_htotal), .raw_s_start(vif.cfg_hs_start), .raw_s_end(vif.cfg_hs_end),
        .offset(trim.hs_offset), .width(trim.hs_width),
        .adj_total(h_adj_total), .adj_s_start(h_adj_start), .adj_s_end(h_adj_end),
        .total(sh_htotal), .bl_start(sh_hbl_start), .bl_end(sh_hbl_end),
        .s_start(sh_hs_start), .s_end(sh_hs_end),
        .cnt(h_cnt), .last(h_last), .bl(h_bl), .sy(h_sy)
    );

    // Vertical flags compare on every pixel enable, not only at line wrap.
    vt_axis #(.CW(CW)) u_v (
        .clk(clk), .reset(reset), .ce(ce_pix), .step(ce_pix & h_last),
        .raw_total(vif.cfg_vtotal), .raw_s_start(vif.cfg_vs_start), .raw_s_end(vif.cfg_vs_end),
        .offset(trim.vs_offset), .width(trim.vs_width),
        .adj_total(v_adj_total), .adj_s_start(v_adj_start), .adj_s_end(v_adj_end),
        .total(sh_vtotal), .bl_start(sh_vbl_start), .bl_end(sh_vbl_end),
        .s_start(sh_vs_start), .s_end(sh_vs_end),
        .cnt(v_cnt), .last(v_last), .bl(v_bl), .sy(v_sy)
    );

    always_ff @(posedge clk) begin
        if (reset)                          field_q <= 1'b0;
        else if (ce_pix & h_last & v_last)  field_q <= ~field_q;
    end

    assign vif.hc    = h_cnt;
    assign vif.vc    = v_cnt;
    assign vif.hbl   = h_bl;
    assign vif.vbl   = v_bl;
    assign vif.hsync = ~(h_sy ^ sh_hs_pol);
    assign vif.vsync = ~(v_sy ^ sh_vs_pol);
    assign vif.de    = ~h_bl & ~v_bl;
    assign vif.field = field_q;

    if (IRQ_EN) begin : g_irq
        assign vif.irq = ~reset & ce_pix & (h_cnt == sh_hbl_start) & (v_cnt == sh_irq_line);
    end else begin : g_no_irq
        assign vif.irq = 1'b0;
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - directed self-checking bench for video_timing_gen.
module tb_video_timing_gen;
    import vt_pkg::*;

    logic clk, reset, ce_pix;
    int   checks, failures;
    int   irq_cnt, irq_idle, hs_low;
    int   e_h, e_v, e_a, e_b, e_c;
    int   p, hh, vv;
    bit   x_hbl, x_vbl, x_hs, x_vs;
    logic [8:0] irq_h, irq_v;

    video_timing_gen_if #(.CW(9)) vif ();

    video_timing_gen #(.CW(9), .IRQ_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .ce_pix(ce_pix), .vif(vif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Leaves ce_pix=1 so the following posedge advances; state seen here is pre-advance.
    task automatic step(input int gap);
        for (int g = 0; g < gap; g++) begin
            @(negedge clk); ce_pix = 1'b0; #1;
            if (vif.irq !== 1'b0) irq_idle++;
        end
        @(negedge clk); ce_pix = 1'b1; #1;
        if (vif.irq === 1'b1) begin
            irq_cnt++;
            irq_h = vif.hc;
            irq_v = vif.vc;
        end
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b1; ce_pix = 1'b1;
        @(negedge clk); reset = 1'b0; ce_pix = 1'b0; #1;
        irq_cnt = 0; irq_idle = 0;
    endtask

    task automatic cfg_small(input int ht, input int vt, input int irq_line);
        vif.cfg_htotal = 9'(ht);   vif.cfg_vtotal = 9'(vt);
        vif.cfg_hbl_start = 9'd5;  vif.cfg_hbl_end = 9'd1;
        vif.cfg_vbl_start = 9'd7;  vif.cfg_vbl_end = 9'd1;
        vif.cfg_hs_start = 9'd2;   vif.cfg_hs_end = 9'd4;
        vif.cfg_vs_start = 9'd3;   vif.cfg_vs_end = 9'd5;
        vif.hs_offset = 4'sd0; vif.vs_offset = 4'sd0; vif.hs_width = 4'sd0; vif.vs_width = 4'sd0;
        vif.cfg_hs_pol = 1'b1; vif.cfg_vs_pol = 1'b1;
        vif.cfg_irq_line = 9'(irq_line);
    endtask

    initial begin
        checks = 0; failures = 0; reset = 1'b1; ce_pix = 1'b0;
        irq_h = '0; irq_v = '0;

        // Defaults, hsync active-low, irq on line 0 at h=hbl_start.
        vif.cfg_htotal = 9'(DEF_HTOTAL);       vif.cfg_vtotal = 9'(DEF_VTOTAL);
        vif.cfg_hbl_start = 9'(DEF_HBL_START); vif.cfg_hbl_end = 9'(DEF_HBL_END);
        vif.cfg_vbl_start = 9'(DEF_VBL_START); vif.cfg_vbl_end = 9'(DEF_VBL_END);
        vif.cfg_hs_start = 9'(DEF_HS_START);   vif.cfg_hs_end = 9'(DEF_HS_END);
        vif.cfg_vs_start = 9'(DEF_VS_START);   vif.cfg_vs_end = 9'(DEF_VS_END);
        vif.hs_offset = 4'sd0; vif.vs_offset = 4'sd0; vif.hs_width = 4'sd0; vif.vs_width = 4'sd0;
        vif.cfg_hs_pol = 1'b0; vif.cfg_vs_pol = 1'b1; vif.cfg_irq_line = 9'd0;
        do_reset();
        chk("rst_hc", vif.hc, 0);       chk("rst_vc", vif.vc, 0);
        chk("rst_hbl", vif.hbl, 0);     chk("rst_vbl", vif.vbl, 0);
        chk("rst_hsync", vif.hsync, 1); chk("rst_vsync", vif.vsync, 0);
        chk("rst_de", vif.de, 1);       chk("rst_field", vif.field, 0);
        chk("rst_irq", vif.irq, 0);

        e_h = 0; e_a = 0; e_b = 0; e_c = 0; hs_low = 0;
        for (int n = 0; n < 384; n++) begin
            step(1);
            x_hbl = (n >= 257);
            x_hs  = !(n >= 298 && n <= 329);
            if (vif.hc !== 9'(n)) e_h++;
            if (vif.hbl !== x_hbl) e_a++;
            if (vif.hsync !== x_hs) e_b++;
            if (vif.de !== !x_hbl || vif.vbl !== 1'b0 || vif.vsync !== 1'b0) e_c++;
            if (vif.hsync === 1'b0) hs_low++;
        end
        chk("def_hc_err", e_h, 0);   chk("def_hbl_err", e_a, 0);
        chk("def_hsync_err", e_b, 0); chk("def_de_err", e_c, 0);
        chk("def_hs_low_ce", hs_low, 32);
        chk("def_irq_cnt", irq_cnt, 1); chk("def_irq_h", irq_h, 256); chk("def_irq_v", irq_v, 0);
        chk("def_irq_idle", irq_idle, 0);
        @(negedge clk); ce_pix = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("hold_hc", vif.hc, 0); chk("hold_vc", vif.vc, 1);
        chk("hold_hbl", vif.hbl, 1); chk("hold_de", vif.de, 0);

        // Small raster: 8 x 10, hbl 5/1, vbl 7/1, irq line 4.
        cfg_small(7, 9, 4);
        do_reset();
        e_h = 0; e_v = 0; e_a = 0; e_b = 0; e_c = 0;
        for (int n = 0; n < 151; n++) begin
            step(1);
            p = n % 80; hh = p % 8; vv = p / 8;
            x_hbl = (hh >= 6 || hh <= 1) && n >= 6;
            x_vbl = (p >= 57 || p <= 8) && n >= 57;
            if (vif.hc !== 9'(hh)) e_h++;
            if (vif.vc !== 9'(vv)) e_v++;
            if (vif.vbl !== x_vbl) e_a++;
            if (vif.de !== (!x_hbl && !x_vbl)) e_b++;
            if (vif.field !== (n >= 80)) e_c++;
        end
        chk("a_hc_err", e_h, 0);  chk("a_vc_err", e_v, 0);
        chk("a_vbl_err", e_a, 0); chk("a_de_err", e_b, 0); chk("a_field_err", e_c, 0);
        chk("a_irq_cnt", irq_cnt, 2); chk("a_irq_h", irq_h, 5); chk("a_irq_v", irq_v, 4);
        chk("a_irq_idle", irq_idle, 0);

        // Reset lands at v=8,h=7 of the second frame with blanks set.
        @(negedge clk); reset = 1'b1; ce_pix = 1'b1; #1;
        chk("pre_rst_hc", vif.hc, 7);   chk("pre_rst_vc", vif.vc, 8);
        chk("pre_rst_hbl", vif.hbl, 1); chk("pre_rst_vbl", vif.vbl, 1);
        chk("pre_rst_field", vif.field, 1);
        @(negedge clk); reset = 1'b0; ce_pix = 1'b0; #1;
        chk("mid_rst_hc", vif.hc, 0);      chk("mid_rst_vc", vif.vc, 0);
        chk("mid_rst_hbl", vif.hbl, 0);    chk("mid_rst_vbl", vif.vbl, 0);
        chk("mid_rst_hsync", vif.hsync, 0); chk("mid_rst_vsync", vif.vsync, 0);
        chk("mid_rst_field", vif.field, 0);
        for (int n = 0; n < 80; n++) step(0);
        @(negedge clk); ce_pix = 1'b0; #1;
        chk("restart_field", vif.field, 1);
        chk("restart_hc", vif.hc, 0); chk("restart_vc", vif.vc, 0);

        // Mid-frame htotal 7->11 only applies from the next frame; irq line beyond vtotal.
        cfg_small(7, 3, 4);
        do_reset();
        for (int n = 0; n <= 44; n++) begin
            if (n == 5) vif.cfg_htotal = 9'd11;
            step(0);
            if (n == 16) begin chk("ht_n16_hc", vif.hc, 0); chk("ht_n16_vc", vif.vc, 2); end
            if (n == 32) begin chk("ht_n32_hc", vif.hc, 0); chk("ht_n32_vc", vif.vc, 0); end
            if (n == 40) begin chk("ht_n40_hc", vif.hc, 8); chk("ht_n40_vc", vif.vc, 0); end
            if (n == 44) begin chk("ht_n44_hc", vif.hc, 0); chk("ht_n44_vc", vif.vc, 1); end
        end
        chk("ht_irq_none", irq_cnt, 0);

        // Trims: hs 2-4=-2 -> 6, end 4-4+3=3; vs 257+7=264 -> 0, end 265+14=279 -> 15.
        cfg_small(7, 263, 300);
        vif.cfg_vs_start = 9'(DEF_VS_START); vif.cfg_vs_end = 9'(DEF_VS_END);
        vif.hs_offset = -4'sd4; vif.hs_width = 4'sd3;
        vif.vs_offset = 4'sd7;  vif.vs_width = 4'sd7;
        do_reset();
        e_v = 0; e_a = 0; e_b = 0;
        for (int n = 0; n < 4224; n++) begin
            step(0);
            hh = n % 8; vv = (n / 8) % 264;
            x_vs = (vv == 0 && hh >= 1) || (vv >= 1 && vv <= 14) || (vv == 15 && hh == 0);
            x_hs = (hh == 7 || hh <= 3) && n >= 7;
            if (vif.vc !== 9'(vv)) e_v++;
            if (vif.vsync !== x_vs) e_a++;
            if (vif.hsync !== x_hs) e_b++;
        end
        chk("trim_vc_err", e_v, 0);
        chk("trim_vsync_err", e_a, 0);
        chk("trim_hsync_err", e_b, 0);
        chk("trim_irq_none", irq_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
